// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared definitions for the FP issue controller.
//   - op-code encodings (these are also the alu_ctrl values)
//   - controller state enum
//   - default per-op latencies and latency counter width
//   - op_latency(): maps an op code to {legal, latency}
package fp_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_C_EQ = 4'b1010;
  localparam logic [3:0] OP_C_LT = 4'b1000;
  localparam logic [3:0] OP_C_LE = 4'b1100;

  localparam int LAT_ADD_DEF = 2;
  localparam int LAT_MUL_DEF = 3;
  localparam int LAT_DIV_DEF = 8;
  localparam int LAT_CMP_DEF = 1;

  localparam int CNT_W   = 8;
  localparam int LAT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             legal;
    logic [CNT_W-1:0] lat;
  } op_lat_t;

  // Unknown codes report illegal with a latency of 1.
  function automatic op_lat_t op_latency(input logic [3:0] op,
                                         input int lat_add,
                                         input int lat_mul,
                                         input int lat_div,
                                         input int lat_cmp);
    op_lat_t r;
    r.legal = 1'b1;
    r.lat   = CNT_W'(1);
    case (op)
      OP_ADD, OP_SUB:           r.lat = CNT_W'(lat_add);
      OP_MUL:                   r.lat = CNT_W'(lat_mul);
      OP_DIV:                   r.lat = CNT_W'(lat_div);
      OP_C_EQ, OP_C_LT, OP_C_LE: r.lat = CNT_W'(lat_cmp);
      default: begin
        r.legal = 1'b0;
        r.lat   = CNT_W'(1);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_op_decode.sv
// fp_op_decode: combinational decode of a requested FP operation.
// Ports:
//   op     in  4      operation code
//   dbl    in  1      double-precision request
//   legal  out 1      op/precision combination is supported
//   is_cmp out 1      legal compare op
//   lat    out CNT_W  cycles from accept to response (1 for illegal ops)
module fp_op_decode
  import fp_ctrl_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_CMP = LAT_CMP_DEF
) (
  input  logic [3:0]       op,
  input  logic             dbl,
  output logic             legal,
  output logic             is_cmp,
  output logic [CNT_W-1:0] lat
);

  op_lat_t info;

  always_comb begin
    info   = op_latency(op, LAT_ADD, LAT_MUL, LAT_DIV, LAT_CMP);
    // Double precision exists only for add/sub.
    legal  = info.legal & (~dbl | (op == OP_ADD) | (op == OP_SUB));
    is_cmp = legal & ((op == OP_C_EQ) | (op == OP_C_LT) | (op == OP_C_LE));
    lat    = legal ? info.lat : CNT_W'(1);
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: single-op issue controller for the FP ALU datapath.
// Accepts one op over req_valid/req_ready, holds registered operands and
// control on the ALU inputs for the op's latency, captures the result into
// a response buffer, and owns the architectural FP condition flag.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   abort                     synchronous kill of the in-flight op
//   req_valid/req_ready       request handshake (ready = IDLE)
//   req_op, req_double        op code and precision
//   req_a, req_b              64-bit operands (single in [63:32])
//   alu_in0_0..alu_in1_1      registered operand halves to the datapath
//   alu_ctrl, alu_double      registered op code and precision
//   alu_res_0, alu_res_1      datapath result words
//   alu_aeqb/altb/agtb/unord  datapath compare flags
//   rsp_valid/rsp_ready       response handshake
//   rsp_result, rsp_err       response payload and illegal-op flag
//   fpcond                    architectural FP condition flag
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | ALU inputs held, latency counter running
// DONE  | response presented, waiting for rsp_ready
module fp_issue_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int LAT_ADD = LAT_ADD_DEF,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_CMP = LAT_CMP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_double,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_in0_0,
  output logic [31:0] alu_in0_1,
  output logic [31:0] alu_in1_1,
  output logic [31:0] alu_in1_0,
  output logic [3:0]  alu_ctrl,
  output logic        alu_double,
  input  logic [31:0] alu_res_0,
  input  logic [31:0] alu_res_1,
  input  logic        alu_aeqb,
  input  logic        alu_altb,
  input  logic        alu_agtb,
  input  logic        alu_unord,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_err,
  output logic        fpcond
);

  if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1 || LAT_CMP < 1 ||
      LAT_ADD > LAT_MAX || LAT_MUL > LAT_MAX ||
      LAT_DIV > LAT_MAX || LAT_CMP > LAT_MAX) begin : g_bad_latency
    $error("fp_issue_ctrl: every latency must be between 1 and %0d", LAT_MAX);
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      a_q, b_q;
  logic [3:0]       op_q;
  logic             dbl_q;
  logic             legal_q, cmp_q;
  logic [63:0]      rsp_result_q;
  logic             rsp_err_q;
  logic             fpcond_q;

  logic             accept, capture;
  logic             cmp_val;
  logic             dec_legal, dec_cmp;
  logic [CNT_W-1:0] dec_lat;

  // agtb is not needed by any supported compare.
  logic unused_agtb;
  assign unused_agtb = alu_agtb;

  fp_op_decode #(
    .LAT_ADD (LAT_ADD),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_CMP (LAT_CMP)
  ) u_decode (
    .op     (req_op),
    .dbl    (req_double),
    .legal  (dec_legal),
    .is_cmp (dec_cmp),
    .lat    (dec_lat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Illegal ops also pass through EXEC (decode gives them latency 1), so
  // their error response shows up one cycle after accept like a 1-cycle op.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      accept  = 1'b0;
      capture = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // Unordered operands never set the condition flag.
  always_comb begin
    cmp_val = 1'b0;
    case (op_q)
      OP_C_EQ: cmp_val = alu_aeqb;
      OP_C_LT: cmp_val = alu_altb;
      OP_C_LE: cmp_val = alu_altb | alu_aeqb;
      default: cmp_val = 1'b0;
    endcase
    if (alu_unord) cmp_val = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      dbl_q        <= 1'b0;
      legal_q      <= 1'b0;
      cmp_q        <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      fpcond_q     <= 1'b0;
    end else begin
      if (accept) begin
        a_q     <= req_a;
        b_q     <= req_b;
        op_q    <= req_op;
        dbl_q   <= req_double;
        legal_q <= dec_legal;
        cmp_q   <= dec_cmp;
        cnt_q   <= dec_lat;
        if (!dec_legal) begin
          rsp_result_q <= '0;
          rsp_err_q    <= 1'b1;
        end
      end else if (state_q == ST_EXEC && !abort) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (capture && legal_q) begin
        rsp_err_q <= 1'b0;
        if (cmp_q) begin
          rsp_result_q <= '0;
          fpcond_q     <= cmp_val;
        end else if (dbl_q) begin
          rsp_result_q <= {alu_res_0, alu_res_1};
        end else begin
          rsp_result_q <= {alu_res_0, 32'h0};
        end
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign fpcond     = fpcond_q;

  assign alu_in0_0  = a_q[63:32];
  assign alu_in0_1  = a_q[31:0];
  assign alu_in1_0  = b_q[63:32];
  assign alu_in1_1  = b_q[31:0];
  assign alu_ctrl   = op_q;
  assign alu_double = dbl_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Testbench for fp_issue_ctrl: behavioural FP datapath, scoreboard of
// expected responses filled at accept, and an independent monitor.
module tb_fp_issue_ctrl;

  localparam int LA = 2;
  localparam int LM = 3;
  localparam int LD = 8;
  localparam int LC = 1;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0100, MUL = 4'b0001, DIV = 4'b0011;
  localparam logic [3:0] CEQ = 4'b1010, CLT = 4'b1000, CLE = 4'b1100;

  logic        clk, rst_n, abort;
  logic        req_valid, req_ready, req_double;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] alu_in0_0, alu_in0_1, alu_in1_1, alu_in1_0;
  logic [3:0]  alu_ctrl;
  logic        alu_double;
  logic [31:0] alu_res_0, alu_res_1;
  logic        alu_aeqb, alu_altb, alu_agtb, alu_unord;
  logic        rsp_valid, rsp_ready, rsp_err, fpcond;
  logic [63:0] rsp_result;

  fp_issue_ctrl #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_CMP(LC)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_double(req_double), .req_a(req_a), .req_b(req_b),
    .alu_in0_0(alu_in0_0), .alu_in0_1(alu_in0_1),
    .alu_in1_1(alu_in1_1), .alu_in1_0(alu_in1_0),
    .alu_ctrl(alu_ctrl), .alu_double(alu_double),
    .alu_res_0(alu_res_0), .alu_res_1(alu_res_1),
    .alu_aeqb(alu_aeqb), .alu_altb(alu_altb), .alu_agtb(alu_agtb), .alu_unord(alu_unord),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .fpcond(fpcond)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr_mode = 2;   // 0 random, 1 hold low, 2 hold high
  logic fc_model = 1'b0;

  typedef struct {
    logic [63:0] res;
    logic        err;
    logic        fc_set;
    logic        fc;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FP helpers ----------------
  function automatic real s2r(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:23] == 8'h00) return 0.0;
    if (s[30:23] == 8'hFF) e = 11'h7FF;
    else                   e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'h000) return {d[63], 31'b0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic is_nan_s(input logic [31:0] s);
    return (s[30:23] == 8'hFF) && (s[22:0] != 23'h0);
  endfunction

  function automatic real arith(input logic [3:0] op, input real x, input real y);
    case (op)
      ADD: return x + y;
      SUB: return x - y;
      MUL: return x * y;
      DIV: return (y != 0.0) ? x / y : 0.0;
      default: return 0.0;
    endcase
  endfunction

  // ---------------- datapath model ----------------
  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic dbl,
                                            input logic [63:0] a, input logic [63:0] b);
    real r;
    if (!(op == ADD || op == SUB || op == MUL || op == DIV)) return 64'hA5A5A5A5_5A5A5A5A;
    if (dbl) begin
      r = arith(op, $bitstoreal(a), $bitstoreal(b));
      return $realtobits(r);
    end
    r = arith(op, s2r(a[63:32]), s2r(b[63:32]));
    return {r2s(r), 32'hDEADBEEF};
  endfunction

  // {unord, aeqb, altb, agtb}; ordering flags are meaningless when unordered, drive them high
  function automatic logic [3:0] cmp_model(input logic [31:0] sa, input logic [31:0] sbv);
    real x, y;
    if (is_nan_s(sa) || is_nan_s(sbv)) return 4'b1111;
    x = s2r(sa);
    y = s2r(sbv);
    return {1'b0, x == y, x < y, x > y};
  endfunction

  always_comb begin
    logic [63:0] r;
    r = alu_model(alu_ctrl, alu_double, {alu_in0_0, alu_in0_1}, {alu_in1_0, alu_in1_1});
    alu_res_0 = r[63:32];
    alu_res_1 = r[31:0];
    {alu_unord, alu_aeqb, alu_altb, alu_agtb} = cmp_model(alu_in0_0, alu_in1_0);
  end

  // ---------------- reference model ----------------
  function automatic exp_t ref_model(input logic [3:0] op, input logic dbl,
                                     input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    real x, y;
    logic is_arith, is_cmp;
    e.res = '0; e.err = 1'b0; e.fc_set = 1'b0; e.fc = 1'b0; e.lat = 1; e.acc = 0;
    is_arith = (op == ADD || op == SUB || op == MUL || op == DIV);
    is_cmp   = (op == CEQ || op == CLT || op == CLE);
    if (!(is_arith || is_cmp) || (dbl && !(op == ADD || op == SUB))) begin
      e.err = 1'b1;
      return e;
    end
    if (is_cmp) begin
      x = s2r(a[63:32]);
      y = s2r(b[63:32]);
      e.lat = LC;
      e.fc_set = 1'b1;
      e.fc = (op == CEQ) ? (x == y) : (op == CLT) ? (x < y) : (x <= y);
      return e;
    end
    e.lat = (op == MUL) ? LM : (op == DIV) ? LD : LA;
    if (dbl) e.res = $realtobits(arith(op, $bitstoreal(a), $bitstoreal(b)));
    else     e.res = {r2s(arith(op, s2r(a[63:32]), s2r(b[63:32]))), 32'h0};
    return e;
  endfunction

  function automatic exp_t kexp(input logic [63:0] res, input logic err,
                                input logic fc, input int lat);
    exp_t e;
    e.res = res; e.err = err; e.fc_set = 1'b1; e.fc = fc; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic send(input logic [3:0] op, input logic dbl, input logic [63:0] a,
                      input logic [63:0] b, input exp_t e);
    int n = 0;
    @(negedge clk); #1;
    req_valid = 1'b1; req_op = op; req_double = dbl; req_a = a; req_b = b;
    while (!req_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {63'b0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (!e.fc_set) e.fc = fc_model;
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // ---------------- response driver and monitor ----------------
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  initial begin
    bit seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {63'b0, rsp_valid}, 64'd0);
        end else begin
          e = sb[0];
          if (!seen) begin
            seen = 1;
            chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_err", {63'b0, rsp_err}, {63'b0, e.err});
          chk("fpcond_at_rsp", {63'b0, fpcond}, {63'b0, e.fc});
          chk("req_ready_in_done", {63'b0, req_ready}, 64'd0);
          if (rsp_ready) begin
            fc_model = e.fc;
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end else begin
        chk("fpcond_hold", {63'b0, fpcond}, {63'b0, fc_model});
        if (sb.size() != 0) chk("req_ready_in_exec", {63'b0, req_ready}, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [31:0] spool [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000,
                             32'h40C00000, 32'hBFC00000, 32'h40800000, 32'hC1200000};
  logic [63:0] dpool [5] = '{64'h3FF0000000000000, 64'h4000000000000000, 64'h3FD0000000000000,
                             64'hC008000000000000, 64'h4024000000000000};
  logic [3:0]  ops   [10] = '{ADD, SUB, MUL, DIV, CEQ, CLT, CLE, 4'b0111, 4'b0010, 4'b1111};

  initial begin
    rst_n = 1'b0; abort = 1'b0; req_valid = 1'b0; req_op = '0; req_double = 1'b0;
    req_a = '0; req_b = '0;
    #1;
    chk("reset_req_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_rsp_err", {63'b0, rsp_err}, 64'd0);
    chk("reset_fpcond", {63'b0, fpcond}, 64'd0);
    chk("reset_alu_ops", {alu_in0_0, alu_in1_1}, 64'd0);
    chk("reset_alu_ctrl", {59'b0, alu_ctrl, alu_double}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single and double add
    send(ADD, 1'b0, 64'h3F800000_00000000, 64'h40000000_00000000,
         kexp(64'h40400000_00000000, 1'b0, 1'b0, 2));
    send(ADD, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000,
         kexp(64'h4008000000000000, 1'b0, 1'b0, 2));
    wait_drain();

    // divide with response backpressure
    rr_mode = 1;
    send(DIV, 1'b0, 64'h40C00000_00000000, 64'h40000000_00000000,
         kexp(64'h40400000_00000000, 1'b0, 1'b0, 8));
    repeat (13) @(posedge clk);
    #2 rr_mode = 2;
    wait_drain();

    // compares
    send(CLT, 1'b0, 64'h3F800000_00000000, 64'h40000000_00000000, kexp(64'h0, 1'b0, 1'b1, 1));
    send(CLE, 1'b0, 64'h40000000_00000000, 64'h40000000_00000000, kexp(64'h0, 1'b0, 1'b1, 1));
    send(CEQ, 1'b0, 64'h3F800000_00000000, 64'h7FC00000_00000000, kexp(64'h0, 1'b0, 1'b0, 1));
    send(CLE, 1'b0, 64'h3F800000_00000000, 64'h40000000_00000000, kexp(64'h0, 1'b0, 1'b1, 1));

    // illegal ops leave fpcond alone
    send(MUL, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, kexp(64'h0, 1'b1, 1'b1, 1));
    send(4'b0111, 1'b0, 64'h3F800000_00000000, 64'h40000000_00000000, kexp(64'h0, 1'b1, 1'b1, 1));
    wait_drain();

    // abort in the third EXEC cycle of a divide
    send(DIV, 1'b0, 64'h40C00000_00000000, 64'h40000000_00000000,
         kexp(64'h40400000_00000000, 1'b0, 1'b1, 8));
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_req_ready", {63'b0, req_ready}, 64'd1);
    chk("abort_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("abort_fpcond", {63'b0, fpcond}, 64'd1);
    sb.delete();
    repeat (12) @(posedge clk);

    // reset in the middle of EXEC
    send(ADD, 1'b0, 64'h3F800000_00000000, 64'h40000000_00000000,
         kexp(64'h40400000_00000000, 1'b0, 1'b1, 2));
    wait_drain();
    send(DIV, 1'b0, 64'h40C00000_00000000, 64'h40000000_00000000,
         kexp(64'h40400000_00000000, 1'b0, 1'b1, 8));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("midrst_rsp_result", rsp_result, 64'd0);
    chk("midrst_rsp_err", {63'b0, rsp_err}, 64'd0);
    chk("midrst_fpcond", {63'b0, fpcond}, 64'd0);
    chk("midrst_alu", {alu_in0_0, 27'b0, alu_ctrl, alu_double}, 64'd0);
    sb.delete();
    fc_model = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // randomized traffic
    rr_mode = 0;
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic        dbl;
      logic [63:0] a, b;
      op = ops[$urandom_range(0, 9)];
      if (op == ADD || op == SUB) dbl = ($urandom_range(0, 1) == 1);
      else                        dbl = ($urandom_range(0, 9) == 0);
      if (dbl) begin
        a = dpool[$urandom_range(0, 4)];
        b = dpool[$urandom_range(0, 4)];
      end else begin
        a = {spool[$urandom_range(0, 7)], 32'($urandom)};
        b = {spool[$urandom_range(0, 7)], 32'($urandom)};
        if ((op == CEQ || op == CLT || op == CLE) && $urandom_range(0, 5) == 0)
          b[63:32] = 32'h7FC00000;
      end
      send(op, dbl, a, b, ref_model(op, dbl, a, b));
    end
    rr_mode = 2;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
